// File: rtl/keypad_scan_debounce.sv
// 4x3 matrix keypad front end: column scan, per-key debounce, and key encoding.
// Emits one key_valid strobe per accepted press and a key_held level until release.
module keypad_scan_debounce #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    col_q, col_d;
  logic [3:0]    lat_row_q, lat_row_d;
  logic [CW-1:0] match_q, match_d;
  logic [CW-1:0] rel_q, rel_d;
  logic          valid_q, valid_d;
  logic [3:0]    code_q, code_d;
  logic          held_q, held_d;

  logic          sample;
  logic          row_none;
  logic          row_single;
  logic          accept;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    return (cnt >= CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

  function automatic logic [2:0] rotate(input logic [2:0] c);
    return {c[1:0], c[2]};
  endfunction

  function automatic logic [1:0] row_idx(input logic [3:0] r);
    if (r[3])      return 2'd3;
    else if (r[2]) return 2'd2;
    else if (r[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [1:0] col_idx(input logic [2:0] c);
    if (c[2])      return 2'd2;
    else if (c[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  // Bottom row holds *, 0, # rather than continuing the 1..9 sequence.
  function automatic logic [3:0] encode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    if (r == 2'd3) begin
      case (c)
        2'd0:    code = 4'hA;
        2'd1:    code = 4'h0;
        default: code = 4'hB;
      endcase
    end else begin
      code = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

  assign sample     = (div_q == DIV_LAST);
  assign row_none   = (row == 4'b0000);
  assign row_single = !row_none && ((row & (row - 4'd1)) == 4'b0000);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= SCAN;
      div_q     <= '0;
      col_q     <= 3'b001;
      lat_row_q <= '0;
      match_q   <= '0;
      rel_q     <= '0;
      valid_q   <= 1'b0;
      code_q    <= 4'h0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      col_q     <= col_d;
      lat_row_q <= lat_row_d;
      match_q   <= match_d;
      rel_q     <= rel_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      held_q    <= held_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = sample ? '0 : div_q + 1'b1;
    col_d     = col_q;
    lat_row_d = lat_row_q;
    match_d   = match_q;
    rel_d     = rel_q;
    valid_d   = 1'b0;
    code_d    = code_q;
    held_d    = held_q;
    accept    = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (sample) begin
          if (row_single) begin
            lat_row_d = row;
            match_d   = CW'(1);
            if (DEBOUNCE_CNT <= 1) accept = 1'b1;
            else                   state_d = DEBOUNCE;
          end else begin
            col_d = rotate(col_q);
          end
        end
      end
      DEBOUNCE: begin
        if (sample) begin
          if (row == lat_row_q) begin
            match_d = sat_inc(match_q);
            if (sat_inc(match_q) >= CNT_MAX) accept = 1'b1;
          end else begin
            match_d = '0;
            col_d   = rotate(col_q);
            state_d = SCAN;
          end
        end
      end
      HELD: begin
        if (sample) begin
          if (row_none) begin
            rel_d = sat_inc(rel_q);
            if (sat_inc(rel_q) >= CNT_MAX) begin
              rel_d   = '0;
              held_d  = 1'b0;
              col_d   = rotate(col_q);
              state_d = SCAN;
            end
          end else begin
            rel_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase

    // Column stays frozen on acceptance, so col_q still names the pressed column.
    if (accept) begin
      state_d = HELD;
      valid_d = 1'b1;
      code_d  = encode(row_idx(row), col_idx(col_q));
      held_d  = 1'b1;
      match_d = '0;
      rel_d   = '0;
    end
  end

  always_comb begin
    col       = col_q;
    key_valid = valid_q;
    key_code  = code_q;
    key_held  = held_q;
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with SCAN_DIV=4, DEBOUNCE_CNT=3 and a
// keypad model that closes row r when key (r,c) is pressed and column c is driven.
module tb_keypad_scan_debounce;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [2:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [11:0] keys = '0;

  int vectors = 0;
  int errors  = 0;
  int ncyc;

  keypad_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  always #5 clock = ~clock;

  always_comb begin
    row = '0;
    for (int r = 0; r < 4; r++) row[r] = |(keys[r*3 +: 3] & col);
  end

  always @(posedge clock or posedge reset) begin
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  function automatic logic [2:0] col_rot(input logic [2:0] base, input int n);
    logic [2:0] c;
    c = base;
    for (int i = 0; i < n % 3; i++) c = {c[1:0], c[2]};
    return c;
  endfunction

  task automatic test_reset();
    logic [8:0] exp;
    keys  = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    vectors++;
    if ({col, key_valid, key_code, key_held} !== {3'b001, 1'b0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got col=%b v=%b code=%h held=%b, want col=001 v=0 code=0 held=0",
               col, key_valid, key_code, key_held);
    end
    reset = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      exp = {col_rot(3'b001, k / 4), 1'b0, 4'h0, 1'b0};
      vectors++;
      if ({col, key_valid, key_code, key_held} !== exp) begin
        errors++;
        $display("FAIL idle_scan k=%0d: got %b want %b", k, {col, key_valid, key_code, key_held}, exp);
      end
    end
  endtask

  task automatic test_key5();
    logic [8:0] exp;
    keys = 12'(1) << 4;
    for (int k = 16; k <= 64; k++) begin
      @(negedge clock);
      exp = {(k < 64) ? 3'b010 : 3'b100, (k == 28), (k < 28) ? 4'h0 : 4'h5, (k >= 28 && k < 64)};
      vectors++;
      if ({col, key_valid, key_code, key_held} !== exp) begin
        errors++;
        $display("FAIL key5 k=%0d: got %b want %b", k, {col, key_valid, key_code, key_held}, exp);
      end
      if (k == 55) keys = '0;
    end
  endtask

  task automatic test_bounce();
    logic [8:0] exp;
    logic [2:0] ec;
    for (int k = 65; k <= 92; k++) begin
      @(negedge clock);
      if (k < 68)      ec = 3'b100;
      else if (k < 72) ec = 3'b001;
      else if (k < 80) ec = 3'b010;
      else             ec = col_rot(3'b100, (k - 80) / 4);
      exp = {ec, 1'b0, 4'h5, 1'b0};
      vectors++;
      if ({col, key_valid, key_code, key_held} !== exp) begin
        errors++;
        $display("FAIL bounce k=%0d: got %b want %b", k, {col, key_valid, key_code, key_held}, exp);
      end
      if (k == 73) keys = 12'(1) << 7;
      if (k == 76) keys = '0;
    end
  endtask

  task automatic test_multi();
    logic [8:0] exp;
    logic [2:0] ec;
    keys = (12'(1) << 0) | (12'(1) << 3);
    for (int k = 93; k <= 144; k++) begin
      @(negedge clock);
      if (k < 124)      ec = col_rot(3'b100, (k - 92) / 4);
      else if (k < 144) ec = 3'b001;
      else              ec = 3'b010;
      exp = {ec, (k == 132), (k < 132) ? 4'h5 : 4'h1, (k >= 132 && k < 144)};
      vectors++;
      if ({col, key_valid, key_code, key_held} !== exp) begin
        errors++;
        $display("FAIL multi k=%0d: got %b want %b", k, {col, key_valid, key_code, key_held}, exp);
      end
      if (k == 112) keys = 12'(1) << 0;
      if (k == 133) keys = '0;
    end
  endtask

  task automatic test_special_key(input int idx, input logic [3:0] exp_code, input int extra);
    bit         got;
    bit         released;
    bit         held_ok;
    int         strobes;
    logic [3:0] code;
    got = 0; released = 0; held_ok = 1; strobes = 0; code = 4'hx;
    keys = 12'(1) << idx;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock);
      if (key_valid) begin
        got  = 1;
        code = key_code;
      end
    end
    vectors++;
    if (!got) begin
      errors++;
      $display("FAIL special_strobe key%0d: got no strobe in 60 cycles, want one", idx);
    end
    vectors++;
    if (code !== exp_code) begin
      errors++;
      $display("FAIL special_code key%0d: got %h want %h", idx, code, exp_code);
    end
    if (extra >= 0) keys = keys | (12'(1) << extra);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (key_valid) strobes++;
      if (!key_held) held_ok = 0;
    end
    vectors++;
    if (strobes !== 0 || !held_ok) begin
      errors++;
      $display("FAIL special_held key%0d: got strobes=%0d held_ok=%0d want 0 and 1", idx, strobes, held_ok);
    end
    keys = '0;
    for (int i = 0; i < 60 && !released; i++) begin
      @(negedge clock);
      if (key_valid) strobes++;
      if (!key_held) released = 1;
    end
    vectors++;
    if (!released || strobes !== 0 || key_code !== exp_code) begin
      errors++;
      $display("FAIL special_release key%0d: got released=%0d strobes=%0d code=%h want 1 0 %h",
               idx, released, strobes, key_code, exp_code);
    end
  endtask

  task automatic test_specials();
    test_special_key(9, 4'hA, 2);
    test_special_key(10, 4'h0, -1);
    test_special_key(11, 4'hB, -1);
  endtask

  task automatic test_reset_held();
    logic [8:0] exp;
    bit         got;
    got  = 0;
    keys = 12'(1) << 8;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock);
      if (key_valid) got = 1;
    end
    repeat (5) @(negedge clock);
    vectors++;
    if (!got || key_held !== 1'b1 || key_code !== 4'h9) begin
      errors++;
      $display("FAIL pre_reset_held: got strobe=%0d held=%b code=%h want 1 1 9", got, key_held, key_code);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({col, key_valid, key_code, key_held} !== {3'b001, 1'b0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %b want %b", {col, key_valid, key_code, key_held},
               {3'b001, 1'b0, 4'h0, 1'b0});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      exp = {(k < 8) ? col_rot(3'b001, k / 4) : 3'b100, (k == 20), (k < 20) ? 4'h0 : 4'h9, (k >= 20)};
      vectors++;
      if ({col, key_valid, key_code, key_held} !== exp) begin
        errors++;
        $display("FAIL post_reset k=%0d: got %b want %b", k, {col, key_valid, key_code, key_held}, exp);
      end
    end
    keys = '0;
  endtask

  initial begin
    test_reset();
    test_key5();
    test_bounce();
    test_multi();
    test_specials();
    test_reset_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
